// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: panel-side receiver for the 4-wire LCD serial link (CSX, DC, SCK, SDA).
// Oversamples the link in the clk domain and assembles 8-bit command/parameter
// bytes and 12-bit RGB444 pixels. Decodes CASET, RASET and RAMWR, and emits
// framebuffer write strobes with addresses that auto-increment inside the
// programmed window.

module lcd_spi_rx #(
    parameter int H_RES       = 160,
    parameter int V_RES       = 80,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        LCD_CSX,
    input  logic        LCD_DC,
    input  logic        LCD_SCK,
    input  logic        LCD_SDA,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        param_valid,
    output logic [7:0]  param_byte,
    output logic        pixel_we,
    output logic [13:0] pixel_addr,
    output logic [11:0] pixel_data,
    output logic        ramwr_active,
    output logic        frame_err
);

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // 9-bit limits so coordinates up to 255 compare correctly against the panel size.
    localparam logic [8:0] H_LIM = 9'(H_RES);
    localparam logic [8:0] V_LIM = 9'(V_RES);

    typedef enum logic [1:0] {
        IDLE,
        PARAM_CASET,
        PARAM_RASET,
        RAMWR
    } state_t;

    // Synchronizer chains; the link-side end of each chain is bit 0.
    logic [SYNC_STAGES-1:0] csx_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   prev_sck;

    logic s_csx;
    logic s_dc;
    logic s_sck;
    logic s_sda;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [11:0] shift_reg;
    logic [2:0]  param_idx;
    logic [7:0]  xs;
    logic [7:0]  xe;
    logic [7:0]  ys;
    logic [7:0]  ye;
    logic [7:0]  cur_x;
    logic [7:0]  cur_y;

    logic        sck_rise;
    logic [11:0] shift_next;
    logic [3:0]  bit_cnt_next;
    logic [3:0]  word_len;
    logic        word_done;
    logic [7:0]  rx_byte;
    logic        pixel_in_range;
    logic [13:0] pixel_addr_calc;

    assign s_csx = csx_sync[SYNC_STAGES-1];
    assign s_dc  = dc_sync[SYNC_STAGES-1];
    assign s_sck = sck_sync[SYNC_STAGES-1];
    assign s_sda = sda_sync[SYNC_STAGES-1];

    assign sck_rise     = s_sck & ~prev_sck;
    assign shift_next   = {shift_reg[10:0], s_sda};
    assign bit_cnt_next = bit_cnt + 4'd1;
    assign rx_byte      = shift_next[7:0];

    // Pixels are 12 bits only while in RAMWR with DC high; everything else is a byte.
    assign word_len  = (state == RAMWR && s_dc) ? 4'd12 : 4'd8;
    assign word_done = sck_rise && !s_csx && (bit_cnt_next == word_len);

    assign pixel_in_range  = ({1'b0, cur_x} < H_LIM) && ({1'b0, cur_y} < V_LIM);
    assign pixel_addr_calc = 14'(cur_y) * 14'(H_RES) + 14'(cur_x);

    // Bring the four link inputs into the clk domain and keep the previous SCK for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every sequential assignment is non-blocking so all flops update
        // from the same pre-edge values; blocking here would collapse the chain.
        if (rst) begin
            csx_sync <= '1;
            dc_sync  <= '0;
            sck_sync <= '0;
            sda_sync <= '0;
            prev_sck <= 1'b0;
        end else begin
            csx_sync <= {csx_sync[SYNC_STAGES-2:0], LCD_CSX};
            dc_sync  <= {dc_sync[SYNC_STAGES-2:0], LCD_DC};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], LCD_SCK};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], LCD_SDA};
            prev_sck <= s_sck;
        end
    end

    // Word assembly, command decode, window registers and pixel address generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            shift_reg    <= 12'd0;
            param_idx    <= 3'd0;
            xs           <= 8'd0;
            xe           <= 8'(H_RES - 1);
            ys           <= 8'd0;
            ye           <= 8'(V_RES - 1);
            cur_x        <= 8'd0;
            cur_y        <= 8'd0;
            cmd_valid    <= 1'b0;
            cmd_byte     <= 8'd0;
            param_valid  <= 1'b0;
            param_byte   <= 8'd0;
            pixel_we     <= 1'b0;
            pixel_addr   <= 14'd0;
            pixel_data   <= 12'd0;
            ramwr_active <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            // NOTE: strobes default low here so each fires for exactly one cycle
            // unless a completed word re-asserts it below.
            cmd_valid   <= 1'b0;
            param_valid <= 1'b0;
            pixel_we    <= 1'b0;
            frame_err   <= 1'b0;

            if (s_csx) begin
                // CSX high dominates a coincident SCK edge; bit_cnt is only
                // non-zero on the first CSX-high cycle after a partial word.
                bit_cnt <= 4'd0;
                if (bit_cnt != 4'd0) begin
                    frame_err <= 1'b1;
                end
            end else if (sck_rise) begin
                shift_reg <= shift_next;
                if (!word_done) begin
                    bit_cnt <= bit_cnt_next;
                end else begin
                    bit_cnt <= 4'd0;
                    if (!s_dc) begin
                        // Command byte: the only thing that changes state.
                        cmd_valid <= 1'b1;
                        cmd_byte  <= rx_byte;
                        param_idx <= 3'd0;
                        case (rx_byte)
                            CMD_CASET: begin
                                state        <= PARAM_CASET;
                                ramwr_active <= 1'b0;
                            end
                            CMD_RASET: begin
                                state        <= PARAM_RASET;
                                ramwr_active <= 1'b0;
                            end
                            CMD_RAMWR: begin
                                state        <= RAMWR;
                                ramwr_active <= 1'b1;
                                cur_x        <= xs;
                                cur_y        <= ys;
                            end
                            default: begin
                                state        <= IDLE;
                                ramwr_active <= 1'b0;
                            end
                        endcase
                    end else if (state != RAMWR) begin
                        // Parameter byte: only the low bytes of each 16-bit coordinate matter.
                        param_valid <= 1'b1;
                        param_byte  <= rx_byte;
                        if (param_idx < 3'd4) begin
                            param_idx <= param_idx + 3'd1;
                        end
                        case (state)
                            PARAM_CASET: begin
                                if (param_idx == 3'd1) xs <= rx_byte;
                                if (param_idx == 3'd3) xe <= rx_byte;
                            end
                            PARAM_RASET: begin
                                if (param_idx == 3'd1) ys <= rx_byte;
                                if (param_idx == 3'd3) ye <= rx_byte;
                            end
                            default: ;
                        endcase
                    end else begin
                        // Pixel: write only on-panel cells, but always advance the cursor.
                        if (pixel_in_range) begin
                            pixel_we   <= 1'b1;
                            pixel_addr <= pixel_addr_calc;
                            pixel_data <= shift_next;
                        end
                        if (cur_x == xe) begin
                            cur_x <= xs;
                            cur_y <= (cur_y == ye) ? ys : cur_y + 8'd1;
                        end else begin
                            cur_x <= cur_x + 8'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb_lcd_spi_rx: directed stimulus for lcd_spi_rx with a queue-based scoreboard.
// Stimulus tasks push the expected strobe before driving each word; a monitor
// pops and compares whenever the DUT raises any strobe.

module tb_lcd_spi_rx;

    localparam int K_CMD   = 1;
    localparam int K_PARAM = 2;
    localparam int K_PIX   = 3;
    localparam int K_FERR  = 4;

    typedef struct {
        int          kind;
        logic [13:0] addr;
        logic [11:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        csx;
    logic        dc;
    logic        sck;
    logic        sda;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        param_valid;
    logic [7:0]  param_byte;
    logic        pixel_we;
    logic [13:0] pixel_addr;
    logic [11:0] pixel_data;
    logic        ramwr_active;
    logic        frame_err;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    lcd_spi_rx #(.H_RES(160), .V_RES(80), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .LCD_CSX     (csx),
        .LCD_DC      (dc),
        .LCD_SCK     (sck),
        .LCD_SDA     (sda),
        .cmd_valid   (cmd_valid),
        .cmd_byte    (cmd_byte),
        .param_valid (param_valid),
        .param_byte  (param_byte),
        .pixel_we    (pixel_we),
        .pixel_addr  (pixel_addr),
        .pixel_data  (pixel_data),
        .ramwr_active(ramwr_active),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    task automatic push(input int kind, input logic [13:0] addr, input logic [11:0] data);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        q.push_back(e);
    endtask

    // One word, MSB first; SCK spends 4 clk low and 4 clk high per bit.
    task automatic send_word(input logic d, input logic [11:0] val, input int nbits);
        @(negedge clk);
        dc  = d;
        csx = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            sda = val[i];
            sck = 1'b0;
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
        end
        sck = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        push(K_CMD, 14'd0, {4'd0, b});
        send_word(1'b0, {4'd0, b}, 8);
    endtask

    task automatic send_param(input logic [7:0] b);
        push(K_PARAM, 14'd0, {4'd0, b});
        send_word(1'b1, {4'd0, b}, 8);
    endtask

    task automatic send_pix(input logic [11:0] d, input logic expect_we, input logic [13:0] addr);
        if (expect_we) push(K_PIX, addr, d);
        send_word(1'b1, d, 12);
    endtask

    task automatic end_frame();
        @(negedge clk);
        csx = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, q.size(), 0);
    endtask

    // Scoreboard monitor: any strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            int   n;
            int   kind_act;
            exp_t e;
            n = int'(cmd_valid) + int'(param_valid) + int'(pixel_we) + int'(frame_err);
            if (n > 1) begin
                total++;
                bad++;
                $display("FAIL strobe_count: got %0d strobes in one cycle, want at most 1", n);
            end else if (n == 1) begin
                kind_act = cmd_valid ? K_CMD : param_valid ? K_PARAM : pixel_we ? K_PIX : K_FERR;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got kind %0d, want none", kind_act);
                end else begin
                    e = q.pop_front();
                    check("strobe_kind", kind_act, e.kind);
                    if (kind_act == e.kind) begin
                        case (kind_act)
                            K_CMD:   check("cmd_byte", {24'd0, cmd_byte}, {24'd0, e.data[7:0]});
                            K_PARAM: check("param_byte", {24'd0, param_byte}, {24'd0, e.data[7:0]});
                            K_PIX: begin
                                check("pixel_addr", {18'd0, pixel_addr}, {18'd0, e.addr});
                                check("pixel_data", {20'd0, pixel_data}, {20'd0, e.data});
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_valid"},   {31'd0, cmd_valid},    0);
        check({tag, "_cmd_byte"},    {24'd0, cmd_byte},     0);
        check({tag, "_param_valid"}, {31'd0, param_valid},  0);
        check({tag, "_param_byte"},  {24'd0, param_byte},   0);
        check({tag, "_pixel_we"},    {31'd0, pixel_we},     0);
        check({tag, "_pixel_addr"},  {18'd0, pixel_addr},   0);
        check({tag, "_pixel_data"},  {20'd0, pixel_data},   0);
        check({tag, "_ramwr"},       {31'd0, ramwr_active}, 0);
        check({tag, "_frame_err"},   {31'd0, frame_err},    0);
    endtask

    initial begin
        rst = 1'b1;
        csx = 1'b1;
        dc  = 1'b0;
        sck = 1'b0;
        sda = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Command decode and CASET / RASET window load.
        send_cmd(8'h2A);
        drain("drain_cmd");
        check("cmd_byte_after_caset", {24'd0, cmd_byte}, 32'h2A);
        send_param(8'h00);
        send_param(8'h9E);
        send_param(8'h00);
        send_param(8'h9F);
        drain("drain_caset");
        check("cmd_byte_held", {24'd0, cmd_byte}, 32'h2A);
        send_cmd(8'h2B);
        send_param(8'h00);
        send_param(8'h0A);
        send_param(8'h00);
        send_param(8'h0B);
        drain("drain_raset");
        check("param_byte_held", {24'd0, param_byte}, 32'h0B);
        check("ramwr_before", {31'd0, ramwr_active}, 0);

        // RAMWR with a 2x2 window, including the wrap back to the window origin.
        send_cmd(8'h2C);
        drain("drain_ramwr_cmd");
        check("ramwr_active", {31'd0, ramwr_active}, 1);
        send_pix(12'hF00, 1'b1, 14'd1758);
        send_pix(12'h0F0, 1'b1, 14'd1759);
        send_pix(12'h00F, 1'b1, 14'd1918);
        send_pix(12'hFFF, 1'b1, 14'd1919);
        send_pix(12'h123, 1'b1, 14'd1758);
        drain("drain_wrap");
        end_frame();
        check("ramwr_survives_csx", {31'd0, ramwr_active}, 1);

        // Single-cell window in the bottom-right corner.
        send_cmd(8'h2A);
        send_param(8'h00);
        send_param(8'h9F);
        send_param(8'h00);
        send_param(8'h9F);
        send_cmd(8'h2B);
        send_param(8'h00);
        send_param(8'h4F);
        send_param(8'h00);
        send_param(8'h4F);
        send_cmd(8'h2C);
        send_pix(12'hA5A, 1'b1, 14'd12799);
        send_pix(12'h5A5, 1'b1, 14'd12799);
        send_pix(12'h3C3, 1'b1, 14'd12799);
        drain("drain_single");
        end_frame();

        // Off-panel column: writes suppressed, RAMWR still active.
        send_cmd(8'h2A);
        send_param(8'h00);
        send_param(8'hC8);
        send_param(8'h00);
        send_param(8'hC8);
        send_cmd(8'h2C);
        send_pix(12'h111, 1'b0, 14'd0);
        send_pix(12'h222, 1'b0, 14'd0);
        drain("drain_oor");
        check("ramwr_oor", {31'd0, ramwr_active}, 1);

        // Framing error: 5 bits then CSX high, then a clean command.
        push(K_FERR, 14'd0, 12'd0);
        send_word(1'b0, 12'h015, 5);
        @(negedge clk);
        csx = 1'b1;
        repeat (6) @(negedge clk);
        drain("drain_ferr");
        send_cmd(8'h11);
        drain("drain_after_ferr");
        check("cmd_after_ferr", {24'd0, cmd_byte}, 32'h11);
        check("idle_after_ferr", {31'd0, ramwr_active}, 0);

        // Reset mid-pixel, then full-screen window restored.
        send_cmd(8'h2C);
        drain("drain_ramwr_pre_rst");
        send_word(1'b1, 12'h03F, 6);
        @(negedge clk);
        rst = 1'b1;
        csx = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_cmd(8'h2C);
        send_pix(12'hABC, 1'b1, 14'd0);
        send_pix(12'h456, 1'b1, 14'd1);
        drain("drain_post_rst");
        end_frame();

        repeat (10) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_spi_rx.md
# lcd_spi_rx

Receive-side model of the 4-wire LCD serial link: CSX, DC, SCK, SDA. Oversamples the link in the `clk` domain and assembles 8-bit command and parameter bytes, plus 12-bit RGB444 pixel words. Decodes CASET (0x2A), RASET (0x2B) and RAMWR (0x2C), and emits framebuffer write strobes with auto-incremented addresses inside the programmed window. Used as the panel-side endpoint in loopback benches and as the front end of the on-chip display mirror.

## Interface
- H_RES, 160, panel columns.
- V_RES, 80, panel rows.
- SYNC_STAGES, 2, synchronizer depth on all four link inputs (≥2).
- clk  in  1  system clock; must be ≥4× SCK frequency.
- rst  in  1  reset, asynchronous, active-high.
- LCD_CSX  in  1  chip select, active low.
- LCD_DC  in  1  0 = command, 1 = data; sampled with the final bit of a byte.
- LCD_SCK  in  1  serial clock; data sampled on the rising edge.
- LCD_SDA  in  1  serial data, MSB first.
- cmd_valid  out  1  one-cycle pulse: a command byte was received.
- cmd_byte  out  8  last command byte; held until the next command.
- param_valid  out  1  one-cycle pulse: a parameter byte was received (outside RAMWR).
- param_byte  out  8  last parameter byte; held.
- pixel_we  out  1  one-cycle framebuffer write strobe.
- pixel_addr  out  14  cur_y*H_RES+cur_x.
- pixel_data  out  12  RGB444 pixel.
- ramwr_active  out  1  high while in the RAMWR state.
- frame_err  out  1  one-cycle pulse: CSX rose with a partial word pending.

## Operation
- All four inputs pass through SYNC_STAGES flops. The previous synchronized SCK is also registered; sck_rise = sync_sck & ~prev_sck.
- While synchronized CSX = 1:
  - bit_cnt is cleared every cycle.
  - If bit_cnt ≠ 0 at the first CSX-high cycle, frame_err pulses and the partial word is discarded.
  - CSX high does NOT leave RAMWR.
- On sck_rise with CSX = 0:
  - Shift SDA into a 12-bit shift register and increment bit_cnt.
- Word complete (when the corresponding sck_rise is sampled):
  - **RAMWR and DC = 1:** completes at bit_cnt = 12.
  - **Otherwise:** completes at bit_cnt = 8.
- Completed byte with DC = 0 (command):
  - Pulse cmd_valid and set param_idx = 0.
  - 0x2A → PARAM_CASET.
  - 0x2B → PARAM_RASET.
  - 0x2C → RAMWR; load cur_x = xs, cur_y = ys.
  - Any other value → IDLE.
- Completed byte with DC = 1 outside RAMWR:
  - Pulse param_valid and increment param_idx, saturating at 4.
  - In PARAM_CASET: idx 1 loads xs = byte, idx 3 loads xe = byte. Idx 0 and 2 (high bytes) are ignored.
  - PARAM_RASET uses the same indices for ys and ye.
  - Bytes at idx ≥ 4 pulse param_valid only.
- Completed pixel in RAMWR:
  - If cur_x < H_RES and cur_y < V_RES: pulse pixel_we with the current address and data. Otherwise the write is suppressed, but the address still advances.
  - Advance: if cur_x == xe, set cur_x = xs and cur_y = (cur_y == ye) ? ys : cur_y+1. Otherwise cur_x+1.
  - cur_x and cur_y are 8 bits; the address multiply is computed at 14 bits.
- States: IDLE, PARAM_CASET, PARAM_RASET, RAMWR. Only a command byte changes state.
- Window registers (xs, xe, ys, ye) reset to 0, H_RES-1, 0, V_RES-1.

## Timing
- Reset values:
  - All outputs are 0, including cmd_byte, param_byte, pixel_addr and pixel_data.
  - State is IDLE; bit_cnt and param_idx are 0.
  - Synchronizers reset with CSX = 1 and SCK = 0.
- Latency:
  - cmd_valid, param_valid and pixel_we assert exactly 1 clk after the clk edge on which the final-bit sck_rise is detected.
  - Pin-to-pulse latency is SYNC_STAGES+2 clk, +1 for input phase.
- Data outputs (cmd_byte, param_byte, pixel_addr, pixel_data) change in the same cycle as their strobe.
- At most one strobe fires per cycle.
- Simultaneous CSX rise and sck_rise in the same cycle: CSX wins and the bit is dropped.
- rst mid-word or mid-RAMWR: immediate return to reset values. The window is restored to full screen.
- Back-to-back pixels with continuous CSX low: no gap needed. bit_cnt reloads to 0 in the completion cycle.

## Test plan
- **Command decode:** send 0x2A with DC=0 on bit 8 → cmd_valid once, cmd_byte = 0x2A, no param_valid.
- **CASET/RASET load:**
  - CASET 00 9E 00 9F, then RASET 00 0A 00 0B → four param_valid pulses per command.
  - Resulting window: xs=158, xe=159, ys=10, ye=11.
- **RAMWR wrap:**
  - With the window above, RAMWR then pixels 0xF00, 0x0F0, 0x00F, 0xFFF.
  - Addresses 1758, 1759, 1918, 1919 with matching data.
  - A fifth pixel → addr 1758.
- **Single-cell window:**
  - xs=xe=159, ys=ye=79.
  - Three pixels → three pixel_we at addr 12799.
- **Out of range:**
  - CASET xs=xe=200.
  - RAMWR plus two pixels → no pixel_we; ramwr_active = 1.
- **Framing and reset:**
  - CSX high after 5 bits → frame_err one pulse, no cmd_valid; the next full byte decodes correctly.
  - rst asserted mid-pixel → all outputs 0 and ramwr_active = 0.
